// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
//   Bundles the request, ALU and response signals of alu_arbiter.
//   Signal suffixes are seen from the arbiter: _i flows into it, _o flows out.
//   slave  : arbiter side
//   master : requester / ALU / testbench side
//   req_valid_i  [1:0]  bit k: requester k presents an operation
//   req_a0/1_i   [N-1:0] operand A of requester 0/1
//   req_b0/1_i   [N-1:0] operand B of requester 0/1
//   req_ctr0/1_i [2:0]  ALU control of requester 0/1
//   req_ready_o  [1:0]  bit k: request k accepted this cycle
//   alu_a_o/b_o  [N-1:0] registered ALU operands
//   alu_ctr_o    [2:0]  registered ALU control
//   alu_result_i, alu_zero_i, alu_ovf_i  ALU outputs
//   rsp_valid_o  [1:0]  bit k: response for requester k valid
//   rsp_ready_i  [1:0]  bit k: requester k consumes the response
//   rsp_result_o, rsp_zero_o, rsp_ovf_o  registered response
//   busy_o              arbiter is not idle
interface alu_arbiter_if #(parameter int N = 32);
  logic [1:0]   req_valid_i;
  logic [N-1:0] req_a0_i;
  logic [N-1:0] req_a1_i;
  logic [N-1:0] req_b0_i;
  logic [N-1:0] req_b1_i;
  logic [2:0]   req_ctr0_i;
  logic [2:0]   req_ctr1_i;
  logic [1:0]   req_ready_o;
  logic [N-1:0] alu_a_o;
  logic [N-1:0] alu_b_o;
  logic [2:0]   alu_ctr_o;
  logic [N-1:0] alu_result_i;
  logic         alu_zero_i;
  logic         alu_ovf_i;
  logic [1:0]   rsp_valid_o;
  logic [1:0]   rsp_ready_i;
  logic [N-1:0] rsp_result_o;
  logic         rsp_zero_o;
  logic         rsp_ovf_o;
  logic         busy_o;

  modport slave (
    input  req_valid_i, req_a0_i, req_a1_i, req_b0_i, req_b1_i, req_ctr0_i, req_ctr1_i,
    input  alu_result_i, alu_zero_i, alu_ovf_i, rsp_ready_i,
    output req_ready_o, alu_a_o, alu_b_o, alu_ctr_o,
    output rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_ovf_o, busy_o
  );

  modport master (
    output req_valid_i, req_a0_i, req_a1_i, req_b0_i, req_b1_i, req_ctr0_i, req_ctr1_i,
    output alu_result_i, alu_zero_i, alu_ovf_i, rsp_ready_i,
    input  req_ready_o, alu_a_o, alu_b_o, alu_ctr_o,
    input  rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_ovf_o, busy_o
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational ALU between two requesters with round-robin
//   arbitration, registered operands and a registered response.
//   clk_i  rising-edge clock
//   rst_i  asynchronous active-high reset
//   bus    alu_arbiter_if.slave (request, ALU and response signals)
//
//   state | meaning
//   IDLE  | waiting for a request; grants combinationally, latches operands
//   EXEC  | ALU settles on registered operands; result captured at the edge
//   DONE  | response valid to the owner until it asserts its rsp_ready
module alu_arbiter #(
  parameter int N = 32
) (
  input logic          clk_i,
  input logic          rst_i,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t       state_q, state_d;
  logic         owner_q, owner_d;
  logic         last_grant_q, last_grant_d;
  logic [N-1:0] alu_a_q, alu_a_d;
  logic [N-1:0] alu_b_q, alu_b_d;
  logic [2:0]   alu_ctr_q, alu_ctr_d;
  logic [N-1:0] rsp_result_q, rsp_result_d;
  logic         rsp_zero_q, rsp_zero_d;
  logic         rsp_ovf_q, rsp_ovf_d;
  logic         grant_vld;
  logic         grant_sel;
  logic [1:0]   req_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      // Port 0 wins the first tie after reset.
      last_grant_q <= 1'b1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctr_q    <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctr_q    <= alu_ctr_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_ovf_q    <= rsp_ovf_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctr_d    = alu_ctr_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_ovf_d    = rsp_ovf_q;
    grant_vld    = 1'b0;
    grant_sel    = 1'b0;
    req_ready    = 2'b00;

    case (state_q)
      S_IDLE: begin
        case (bus.req_valid_i)
          2'b01:   begin grant_vld = 1'b1; grant_sel = 1'b0;          end
          2'b10:   begin grant_vld = 1'b1; grant_sel = 1'b1;          end
          2'b11:   begin grant_vld = 1'b1; grant_sel = ~last_grant_q; end
          default: begin grant_vld = 1'b0; grant_sel = 1'b0;          end
        endcase
        if (grant_vld) begin
          req_ready    = grant_sel ? 2'b10 : 2'b01;
          alu_a_d      = grant_sel ? bus.req_a1_i   : bus.req_a0_i;
          alu_b_d      = grant_sel ? bus.req_b1_i   : bus.req_b0_i;
          alu_ctr_d    = grant_sel ? bus.req_ctr1_i : bus.req_ctr0_i;
          owner_d      = grant_sel;
          last_grant_d = grant_sel;
          state_d      = S_EXEC;
        end
      end
      S_EXEC: begin
        rsp_result_d = bus.alu_result_i;
        rsp_zero_d   = bus.alu_zero_i;
        rsp_ovf_d    = bus.alu_ovf_i;
        state_d      = S_DONE;
      end
      S_DONE: begin
        // Only the owner's ready releases the response.
        if (bus.rsp_ready_i[owner_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.req_ready_o  = req_ready;
  assign bus.alu_a_o      = alu_a_q;
  assign bus.alu_b_o      = alu_b_q;
  assign bus.alu_ctr_o    = alu_ctr_q;
  assign bus.rsp_valid_o  = (state_q == S_DONE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_result_o = rsp_result_q;
  assign bus.rsp_zero_o   = rsp_zero_q;
  assign bus.rsp_ovf_o    = rsp_ovf_q;
  assign bus.busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  localparam int N = 32;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic tb_ovf = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   model_last;

  alu_arbiter_if #(.N(N)) bus ();

  alu_arbiter #(.N(N)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural ALU: sum modulo 2^N, zero flag from the sum, overflow forced by the bench.
  assign bus.alu_result_i = bus.alu_a_o + bus.alu_b_o;
  assign bus.alu_zero_i   = (bus.alu_result_i == '0);
  assign bus.alu_ovf_i    = tb_ovf;

  typedef struct {
    logic [1:0]  vld;
    logic [31:0] a0, b0, a1, b1;
    logic [2:0]  c0, c1;
    logic        ovf;
    int          stall;
    logic [1:0]  exp_ready;
    logic [31:0] exp_res;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ready"},  64'(bus.req_ready_o),  64'd0);
    check({tag, " valid"},  64'(bus.rsp_valid_o),  64'd0);
    check({tag, " busy"},   64'(bus.busy_o),       64'd0);
    check({tag, " alu_a"},  64'(bus.alu_a_o),      64'd0);
    check({tag, " alu_b"},  64'(bus.alu_b_o),      64'd0);
    check({tag, " alu_ctr"},64'(bus.alu_ctr_o),    64'd0);
    check({tag, " result"}, 64'(bus.rsp_result_o), 64'd0);
    check({tag, " flags"},  64'({bus.rsp_zero_o, bus.rsp_ovf_o}), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check_all_zero("reset");
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic do_txn(input vec_t v);
    logic [31:0] ga, gb;
    logic [2:0]  gc;
    @(negedge clk_i);
    bus.req_valid_i = v.vld;
    bus.req_a0_i = v.a0; bus.req_b0_i = v.b0; bus.req_ctr0_i = v.c0;
    bus.req_a1_i = v.a1; bus.req_b1_i = v.b1; bus.req_ctr1_i = v.c1;
    #1;
    check("grant ready", 64'(bus.req_ready_o), 64'(v.exp_ready));
    check("idle busy", 64'(bus.busy_o), 64'd0);
    if (v.exp_ready == 2'b00) begin
      @(negedge clk_i);
      check("still idle", 64'(bus.busy_o), 64'd0);
      bus.req_valid_i = 2'b00;
      return;
    end
    ga = v.exp_ready[1] ? v.a1 : v.a0;
    gb = v.exp_ready[1] ? v.b1 : v.b0;
    gc = v.exp_ready[1] ? v.c1 : v.c0;
    @(negedge clk_i);
    bus.req_valid_i = 2'b00;
    tb_ovf = v.ovf;
    check("exec busy", 64'(bus.busy_o), 64'd1);
    check("exec valid", 64'(bus.rsp_valid_o), 64'd0);
    check("exec operands", {ga, gb}, {bus.alu_a_o, bus.alu_b_o});
    check("exec ctr", 64'(bus.alu_ctr_o), 64'(gc));
    @(negedge clk_i);
    tb_ovf = 1'b0;
    check("done valid", 64'(bus.rsp_valid_o), 64'(v.exp_ready));
    check("done result", 64'(bus.rsp_result_o), 64'(v.exp_res));
    check("done flags", 64'({bus.rsp_zero_o, bus.rsp_ovf_o}), 64'({v.exp_zero, v.ovf}));
    for (int i = 0; i < v.stall; i++) begin
      // Non-owner ready must be ignored; new requests must not be accepted.
      bus.rsp_ready_i = ~v.exp_ready;
      bus.req_valid_i = 2'b11;
      #1;
      check("stall no ready", 64'(bus.req_ready_o), 64'd0);
      @(negedge clk_i);
      check("stall valid", 64'(bus.rsp_valid_o), 64'(v.exp_ready));
      check("stall result", 64'(bus.rsp_result_o), 64'(v.exp_res));
      check("stall busy", 64'(bus.busy_o), 64'd1);
    end
    bus.req_valid_i = 2'b00;
    bus.rsp_ready_i = v.exp_ready;
    @(negedge clk_i);
    bus.rsp_ready_i = 2'b00;
    check("release busy", 64'(bus.busy_o), 64'd0);
    check("release valid", 64'(bus.rsp_valid_o), 64'd0);
  endtask

  function automatic vec_t mk(input logic [1:0] vld, input logic [31:0] a0, b0, a1, b1,
                              input logic ovf, input int stall, input logic [1:0] er,
                              input logic [31:0] res);
    vec_t v;
    v.vld = vld; v.a0 = a0; v.b0 = b0; v.a1 = a1; v.b1 = b1;
    v.c0 = 3'b010; v.c1 = 3'b110; v.ovf = ovf; v.stall = stall;
    v.exp_ready = er; v.exp_res = res; v.exp_zero = (res == 32'd0);
    return v;
  endfunction

  initial begin
    bus.req_valid_i = 2'b00;
    bus.req_a0_i = '0; bus.req_b0_i = '0; bus.req_ctr0_i = '0;
    bus.req_a1_i = '0; bus.req_b1_i = '0; bus.req_ctr1_i = '0;
    bus.rsp_ready_i = 2'b00;

    // Expected grants traced from last_grant=1 after reset.
    vecs[0] = mk(2'b01, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 0, 2'b01, 32'd12);
    vecs[1] = mk(2'b11, 32'd1, 32'd1, 32'hFFFFFFFF, 32'd1, 1'b1, 0, 2'b10, 32'd0);
    vecs[2] = mk(2'b11, 32'd100, 32'd200, 32'd9, 32'd9, 1'b0, 5, 2'b01, 32'd300);
    vecs[3] = mk(2'b11, 32'd1, 32'd2, 32'd3, 32'd4, 1'b0, 2, 2'b10, 32'd7);
    vecs[4] = mk(2'b10, 32'd1, 32'd2, 32'd10, 32'd20, 1'b1, 0, 2'b10, 32'd30);
    vecs[5] = mk(2'b11, 32'd0, 32'd0, 32'd5, 32'd5, 1'b0, 1, 2'b01, 32'd0);
    vecs[6] = mk(2'b00, 32'd8, 32'd8, 32'd8, 32'd8, 1'b0, 0, 2'b00, 32'd0);

    #1;
    check_all_zero("por");
    do_reset();
    for (int i = 0; i < 7; i++) do_txn(vecs[i]);

    // Reset during EXEC abandons the operation.
    @(negedge clk_i);
    bus.req_valid_i = 2'b10;
    bus.req_a1_i = 32'd40; bus.req_b1_i = 32'd2;
    @(negedge clk_i);
    bus.req_valid_i = 2'b00;
    check("pre-reset busy", 64'(bus.busy_o), 64'd1);
    #2;
    rst_i = 1'b1;
    #1;
    check_all_zero("async reset");
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("no rsp after reset", 64'({bus.rsp_valid_o, bus.busy_o}), 64'd0);
    end
    // Ties alternate starting from port 0 after reset.
    do_txn(mk(2'b11, 32'd1, 32'd2, 32'd3, 32'd4, 1'b0, 0, 2'b01, 32'd3));
    do_txn(mk(2'b11, 32'd1, 32'd2, 32'd3, 32'd4, 1'b0, 0, 2'b10, 32'd7));
    do_txn(mk(2'b11, 32'd6, 32'd6, 32'd3, 32'd4, 1'b0, 0, 2'b01, 32'd12));

    // Random traffic against a round-robin model.
    do_reset();
    model_last = 1;
    for (int i = 0; i < 40; i++) begin
      vec_t v;
      int g;
      logic [31:0] s;
      v = mk(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom,
             1'($urandom_range(0, 1)), $urandom_range(0, 3), 2'b00, 32'd0);
      if ($urandom_range(0, 3) == 0) v.b0 = -v.a0;
      v.c0 = 3'($urandom); v.c1 = 3'($urandom);
      if (v.vld == 2'b00) g = -1;
      else if (v.vld == 2'b01) g = 0;
      else if (v.vld == 2'b10) g = 1;
      else g = 1 - model_last;
      if (g >= 0) begin
        model_last = g;
        s = (g == 1) ? v.a1 + v.b1 : v.a0 + v.b0;
        v.exp_ready = (g == 1) ? 2'b10 : 2'b01;
        v.exp_res = s;
        v.exp_zero = (s == 32'd0);
      end
      do_txn(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
